// File: rtl/stream_feeder.sv
// stream_feeder: sequences kernel/input memory reads into a 2-entry FIFO feeding a valid/ready controller port.
module stream_feeder #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 32,
  parameter int KERNEL_BASE        = 0,
  parameter int INPUT_BASE         = 1048576
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  con_valid,
  input  logic                  con_ready,
  output logic [DATA_WIDTH-1:0] con_data,
  output logic [1:0]            con_phase
);
  localparam int NG = OUTPUT_NB_CHANNELS / 6;
  localparam int XW = FEATURE_MAP_WIDTH > 1 ? $clog2(FEATURE_MAP_WIDTH) : 1;
  localparam int YW = FEATURE_MAP_HEIGHT > 1 ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);
  localparam int EW = DATA_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, LK, LI, CC, DRAIN} state_t;
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] g_q, g_d;
  logic [ADDR_WIDTH-1:0] kaddr_q, kaddr_d, iaddr_q, iaddr_d;
  logic [EW-1:0] e0_q, e0_d, e1_q, e1_d, new_entry;
  logic [1:0] occ_q, occ_d, phase_now, flph_q;
  logic fl_q, push, pop, issue, active;
  assign active    = state_q == LK || state_q == LI || state_q == CC;
  assign push      = fl_q;
  assign pop       = con_valid && con_ready;
  // Counting this cycle's pop lets a full pipe keep issuing at one read per cycle.
  assign issue     = active && (occ_q + {1'b0, fl_q} - {1'b0, pop}) < 2'd2;
  assign phase_now = state_q == LK ? 2'd0 : state_q == LI ? 2'd1 : 2'd2;
  assign new_entry = {flph_q, mem_rdata};
  assign mem_rd_en = issue;
  assign mem_addr  = state_q == LK ? kaddr_q : iaddr_q;
  assign con_valid = occ_q != 2'd0;
  assign con_data  = e0_q[DATA_WIDTH-1:0];
  assign con_phase = e0_q[DATA_WIDTH+:2];
  assign done      = state_q == DRAIN && occ_q == 2'd0 && !fl_q;
  assign running   = state_q != IDLE && !done;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    g_d     = g_q;
    kaddr_d = kaddr_q;
    iaddr_d = iaddr_q;
    if (state_q == IDLE && start) begin
      state_d = LK;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      g_d     = '0;
      kaddr_d = ADDR_WIDTH'(KERNEL_BASE);
      iaddr_d = ADDR_WIDTH'(INPUT_BASE);
    end else if (state_q == DRAIN && done) begin
      state_d = IDLE;
    end else if (issue && state_q == LK) begin
      kaddr_d = kaddr_q + ADDR_WIDTH'(1);
      cnt_d   = cnt_q == 7'd71 ? 7'd0 : cnt_q + 7'd1;
      state_d = cnt_q == 7'd71 ? LI : LK;
    end else if (issue && state_q == LI) begin
      iaddr_d = iaddr_q + ADDR_WIDTH'(1);
      cnt_d   = cnt_q == 7'd11 ? 7'd0 : cnt_q + 7'd1;
      state_d = cnt_q == 7'd11 ? CC : LI;
    end else if (issue) begin
      iaddr_d = iaddr_q + ADDR_WIDTH'(1);
      cnt_d   = cnt_q == 7'd3 ? 7'd0 : cnt_q + 7'd1;
      if (cnt_q == 7'd3) begin
        x_d = x_q == X_LAST ? '0 : x_q + XW'(1);
        if (x_q == X_LAST) begin
          y_d     = y_q == Y_LAST ? '0 : y_q + YW'(1);
          g_d     = y_q == Y_LAST ? (g_q == G_LAST ? '0 : g_q + GW'(1)) : g_q;
          state_d = y_q != Y_LAST ? LI : g_q == G_LAST ? DRAIN : LK;
          iaddr_d = y_q == Y_LAST ? ADDR_WIDTH'(INPUT_BASE) : iaddr_d;
        end
      end
    end
  end
  always_comb begin
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    e0_d  = pop ? (occ_q == 2'd2 ? e1_q : new_entry) : (push && occ_q == 2'd0 ? new_entry : e0_q);
    e1_d  = push && (pop ? occ_q == 2'd2 : occ_q == 2'd1) ? new_entry : e1_q;
  end
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      kaddr_q <= '0;
      iaddr_q <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      occ_q   <= '0;
      fl_q    <= 1'b0;
      flph_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      kaddr_q <= kaddr_d;
      iaddr_q <= iaddr_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      occ_q   <= occ_d;
      fl_q    <= issue;
      flph_q  <= phase_now;
    end
  end
endmodule

// File: tb/tb_stream_feeder.sv
// tb_stream_feeder: scoreboard bench running a 6-channel and a 12-channel feeder side by side.
module tb_stream_feeder;
  logic clk = 1'b0, arst = 1'b1, start = 1'b0, ready = 1'b0;
  logic running [2], done [2], rd_en [2], valid [2];
  logic [31:0] addr [2];
  logic [15:0] rdata [2], data [2];
  logic [1:0] phase [2];
  logic [17:0] expq [2][$];
  logic [17:0] pword [2];
  logic pv [2], pr [2], dexp [2], done_seen [2];
  int xfers [2], rds [2], outst [2];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  for (genvar i = 0; i < 2; i++) begin : g_dut
    stream_feeder #(
      .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(6 * (i + 1)),
      .DATA_WIDTH(16), .ADDR_WIDTH(32), .KERNEL_BASE(0), .INPUT_BASE(100)
    ) u_dut (
      .clk(clk), .arst_in(arst), .start(start), .running(running[i]), .done(done[i]),
      .mem_rd_en(rd_en[i]), .mem_addr(addr[i]), .mem_rdata(rdata[i]),
      .con_valid(valid[i]), .con_ready(ready), .con_data(data[i]), .con_phase(phase[i])
    );
    always @(posedge clk) if (rd_en[i]) rdata[i] <= addr[i][15:0];
    always @(negedge clk) begin : mon
      logic xf;
      logic [17:0] e;
      if (arst) begin
        pv[i] = 1'b0;
        outst[i] = 0;
        dexp[i] = 1'b0;
      end else begin
        xf = valid[i] && ready;
        if (rd_en[i]) begin
          rds[i]++;
          outst[i]++;
        end
        if (xf) outst[i]--;
        if (rd_en[i]) chk($sformatf("u%0d_occ_le2", i), 32'(outst[i] <= 2), 1);
        if (pv[i] && !pr[i]) begin
          chk($sformatf("u%0d_hold_valid", i), 32'(valid[i]), 1);
          chk($sformatf("u%0d_hold_word", i), {14'd0, phase[i], data[i]}, {14'd0, pword[i]});
        end
        if (xf) begin
          xfers[i]++;
          if (expq[i].size() == 0) chk($sformatf("u%0d_extra_word", i), 32'(expq[i].size()), 1);
          else begin
            e = expq[i].pop_front();
            chk($sformatf("u%0d_word%0d", i, xfers[i]), {14'd0, phase[i], data[i]}, {14'd0, e});
          end
        end
        if (dexp[i] || done[i]) chk($sformatf("u%0d_done", i), 32'(done[i]), 32'(dexp[i]));
        if (done[i]) begin
          chk($sformatf("u%0d_run_low_at_done", i), 32'(running[i]), 0);
          done_seen[i] = 1'b1;
        end
        dexp[i] = xf && expq[i].size() == 0;
        pv[i] = valid[i];
        pr[i] = ready;
        pword[i] = {phase[i], data[i]};
      end
    end
  end
  task automatic fill();
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      for (int g = 0; g <= i; g++) begin
        int ia = 100;
        for (int k = 0; k < 72; k++) expq[i].push_back({2'd0, 16'(72 * g + k)});
        for (int y = 0; y < 2; y++) begin
          for (int k = 0; k < 12; k++) expq[i].push_back({2'd1, 16'(ia++)});
          for (int k = 0; k < 8; k++) expq[i].push_back({2'd2, 16'(ia++)});
        end
      end
      done_seen[i] = 1'b0;
      xfers[i] = 0;
      rds[i] = 0;
    end
  endtask
  task automatic go();
    fill();
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask
  task automatic finish_run(input bit rnd);
    for (int n = 0; n < 4000 && !(done_seen[0] && done_seen[1]); n++)
      @(posedge clk) #1 if (rnd) ready = $urandom_range(0, 9) < 3;
    ready = 1'b1;
    chk("run_completes", 32'(done_seen[0] && done_seen[1]), 1);
    chk("u0_transfers", xfers[0], 112);
    chk("u1_transfers", xfers[1], 224);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_running"}, 32'(running[0]), 0);
    chk({tag, "_done"}, 32'(done[0]), 0);
    chk({tag, "_rd_en"}, 32'(rd_en[0]), 0);
    chk({tag, "_valid"}, 32'(valid[0]), 0);
    chk({tag, "_data"}, 32'(data[0]), 0);
    chk({tag, "_phase"}, 32'(phase[0]), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 arst = 1'b0;
    ready = 1'b1;
    go();
    chk("running_after_start", 32'(running[0]), 1);
    finish_run(0);
    go();
    finish_run(1);
    ready = 1'b0;
    go();
    repeat (20) @(negedge clk);
    chk("stall_valid", 32'(valid[0]), 1);
    chk("stall_data", 32'(data[0]), 0);
    chk("stall_phase", 32'(phase[0]), 0);
    chk("stall_reads_u0", rds[0], 2);
    chk("stall_reads_u1", rds[1], 2);
    @(posedge clk) #1 ready = 1'b1;
    finish_run(0);
    go();
    for (int n = 0; n < 500 && xfers[0] < 50; n++) @(negedge clk);
    chk("reach_50", 32'(xfers[0] >= 50), 1);
    #2 arst = 1'b1;
    #1 chk_zero("midrun_reset");
    repeat (2) @(negedge clk);
    #3 arst = 1'b0;
    go();
    finish_run(0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
